// File: rtl/wb_scoreboard.sv
// wb_scoreboard: register-file write-back arbiter and hazard scoreboard.
// Merges a single-cycle ALU result stream with a long-latency result stream
// into one registered register-file write port, tracks destinations of
// outstanding long ops in a busy vector and stalls decode on RAW/WAW hazards,
// forwarding-window hazards and a full long-op queue.
module wb_scoreboard #(
  parameter int MAX_PEND     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_hold,
  input  logic        long_valid,
  output logic        long_ready,
  input  logic [4:0]  long_rd,
  input  logic [31:0] long_data,
  input  logic        iss_valid,
  input  logic        iss_long,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic [4:0]  iss_rd,
  output logic        iss_stall,
  output logic        write,
  output logic [4:0]  wrAddr,
  output logic [31:0] wrData,
  output logic [2:0]  pending
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [2:0]    MAXP  = 3'(MAX_PEND);

  logic [SW-1:0] r_starve;
  logic [31:0]   r_busy;
  logic [31:0]   w_busy_next;
  logic [2:0]    r_pending;
  logic          r_write;
  logic [4:0]    r_wr_addr;
  logic [31:0]   r_wr_data;

  logic          w_alu_sel;
  logic          w_long_hs;
  logic          w_fwd_hit;
  logic          w_hazard;
  logic          w_iss_acc;
  logic          w_set;
  logic          w_inc;
  logic [4:0]    w_sel_rd;
  logic [31:0]   w_sel_data;
  logic          w_sel_valid;

  // Arbitration: ALU wins unless the long stream has starved long enough.
  assign alu_hold   = (r_starve == LIMIT);
  assign w_alu_sel  = alu_valid && !alu_hold;
  assign long_ready = !reset && !w_alu_sel;
  assign w_long_hs  = long_valid && long_ready;

  assign w_sel_valid = w_alu_sel || w_long_hs;
  assign w_sel_rd    = w_alu_sel ? alu_rd   : long_rd;
  assign w_sel_data  = w_alu_sel ? alu_data : long_data;

  // A result registered last cycle is not yet readable from the file, so
  // sources matching the in-flight write address must wait one cycle.
  assign w_fwd_hit = r_write && (r_wr_addr != 5'd0) &&
                     ((r_wr_addr == iss_rs1) || (r_wr_addr == iss_rs2));

  // Hazards use the pre-edge busy state; a bit cleared this cycle still stalls.
  assign w_hazard = reset || r_busy[iss_rs1] || r_busy[iss_rs2] ||
                    r_busy[iss_rd] || w_fwd_hit ||
                    (iss_long && (r_pending == MAXP));
  assign iss_stall = iss_valid && w_hazard;
  assign w_iss_acc = iss_valid && !iss_stall;
  assign w_inc     = w_iss_acc && iss_long;
  assign w_set     = w_inc && (iss_rd != 5'd0);

  // Per-register busy update; a new issue to the same register wins over a clear.
  assign w_busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign w_busy_next[gi] = (w_set && (iss_rd == 5'(gi)))       ? 1'b1 :
                               (w_long_hs && (long_rd == 5'(gi))) ? 1'b0 :
                               r_busy[gi];
    end
  endgenerate

  // Starve counter: counts consecutive cycles a long result waits unaccepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!long_valid || w_long_hs) begin
      r_starve <= '0;
    end else if (r_starve != LIMIT) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Busy vector and outstanding long-op count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_inc && !w_long_hs) begin
        r_pending <= r_pending + 1'b1;
      end else if (!w_inc && w_long_hs && (r_pending != 3'd0)) begin
        r_pending <= r_pending - 1'b1;
      end
    end
  end

  // Registered write port; results to x0 are consumed without a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_write <= w_sel_valid && (w_sel_rd != 5'd0);
      if (w_sel_valid) begin
        r_wr_addr <= w_sel_rd;
        r_wr_data <= w_sel_data;
      end
    end
  end

  assign write   = r_write;
  assign wrAddr  = r_wr_addr;
  assign wrData  = r_wr_data;
  assign pending = r_pending;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Testbench for wb_scoreboard: directed scenarios plus randomized traffic,
// checked against a behavioural model; write-port results go through a
// scoreboard queue consumed by an independent monitor.
module tb_wb_scoreboard;

  localparam int MAX_PEND     = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_hold;
  logic        long_valid;
  logic        long_ready;
  logic [4:0]  long_rd;
  logic [31:0] long_data;
  logic        iss_valid;
  logic        iss_long;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic [4:0]  iss_rd;
  logic        iss_stall;
  logic        write;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [2:0]  pending;

  always #5 clk = ~clk;

  wb_scoreboard #(.MAX_PEND(MAX_PEND), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_hold(alu_hold),
    .long_valid(long_valid), .long_ready(long_ready), .long_rd(long_rd), .long_data(long_data),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_stall(iss_stall),
    .write(write), .wrAddr(wrAddr), .wrData(wrData), .pending(pending)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          stamp;
    logic [4:0]  a;
    logic [31:0] d;
  } wexp_t;
  wexp_t wq[$];

  // Reference model state
  bit         m_busy[32];
  int         m_pend;
  int         m_starve;
  bit         m_wr;
  logic [4:0] m_wa;
  bit         g_lrdy;
  bit         g_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_pend   = 0;
    m_starve = 0;
    m_wr     = 1'b0;
    m_wa     = '0;
  endtask

  task automatic drv_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    long_valid = 0; long_rd = 0; long_data = 0;
    iss_valid = 0; iss_long = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
  endtask

  task automatic issue(input bit lng, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    iss_valid = 1; iss_long = lng; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd;
  endtask

  // One cycle: inputs are already driven (at negedge). Check combinational
  // outputs against the model, then advance the model across the edge.
  task automatic tick();
    bit hold, asel, lrdy, hs, stall, acc;
    int stamp;
    wexp_t e;
    #1;
    hold  = (m_starve == STARVE_LIMIT);
    asel  = alu_valid && !hold;
    lrdy  = !reset && !asel;
    hs    = long_valid && lrdy;
    stall = iss_valid && (reset || m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd] ||
            (m_wr && m_wa != 0 && (m_wa == iss_rs1 || m_wa == iss_rs2)) ||
            (iss_long && m_pend == MAX_PEND));
    acc   = iss_valid && !stall;
    chk("alu_hold", 32'(alu_hold), 32'(hold));
    chk("long_ready", 32'(long_ready), 32'(lrdy));
    chk("iss_stall", 32'(iss_stall), 32'(stall));
    chk("pending", 32'(pending), 32'(m_pend));
    g_lrdy = long_ready;
    g_hold = alu_hold;
    stamp  = cyc + 1;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      m_wr = 1'b0;
      if (asel || hs) begin
        e.stamp = stamp;
        e.a     = asel ? alu_rd : long_rd;
        e.d     = asel ? alu_data : long_data;
        if (e.a != 0) begin
          wq.push_back(e);
          m_wr = 1'b1;
          m_wa = e.a;
        end
      end
      if (hs) m_busy[long_rd] = 1'b0;
      if (acc && iss_long && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (acc && iss_long && !hs) m_pend++;
      else if (!(acc && iss_long) && hs && m_pend > 0) m_pend--;
      if (!long_valid || hs) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
    end
    @(negedge clk);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  initial begin
    wexp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (write === 1'b1) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write cycle=%0d got addr=%0d data=%h want no write", cyc, wrAddr, wrData);
        end else begin
          e = wq.pop_front();
          chk("write_cycle", 32'(cyc), 32'(e.stamp));
          chk("wrAddr", 32'(wrAddr), 32'(e.a));
          chk("wrData", wrData, e.d);
        end
      end
    end
  end

  initial begin
    int         cnt;
    bit         hold9;
    int         start;
    logic [4:0] lrd;

    reset = 1;
    drv_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();

    // Reset state
    issue(1, 1, 2, 3);
    long_valid = 1; long_rd = 1;
    tick();
    chk("reset_write", 32'(write), 32'd0);
    chk("reset_wrAddr", 32'(wrAddr), 32'd0);
    chk("reset_wrData", wrData, 32'd0);
    reset = 0;
    drv_idle();
    tick();

    // Long op to r5 blocks a reader until its result is written back
    issue(1, 1, 2, 5); tick();
    issue(0, 5, 0, 6); repeat (3) tick();
    long_valid = 1; long_rd = 5; long_data = 32'hDEADBEEF; tick();
    long_valid = 0; tick();
    tick();
    drv_idle(); tick();

    // Starvation: ALU and long streams both presented for ten cycles
    alu_valid = 1; alu_rd = 3; alu_data = 32'h0000_0A1A;
    long_valid = 1; long_rd = 7; long_data = 32'h0000_7777;
    cnt = 0; hold9 = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (!g_lrdy) cnt++;
      if (i == 8) hold9 = g_hold;
    end
    chk("starve_blocked_cycles", 32'(cnt), 32'd8);
    chk("starve_hold_cycle9", 32'(hold9), 32'd1);
    tick();
    drv_idle(); tick();

    // Pending limit
    for (int r = 1; r <= 4; r++) begin
      issue(1, 0, 0, 5'(r)); tick();
    end
    issue(1, 0, 0, 6); tick();
    long_valid = 1; long_rd = 1; long_data = 32'h1111_0001; tick();
    long_valid = 0; tick();
    chk("pend_after_fifth", 32'(pending), 32'd4);
    drv_idle();
    for (int r = 2; r <= 6; r++) begin
      if (r != 5) begin
        long_valid = 1; long_rd = 5'(r); long_data = 32'(r * 3); tick();
      end
    end
    drv_idle(); tick();

    // Results to x0
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; tick();
    drv_idle(); issue(1, 0, 0, 0); tick();
    drv_idle(); long_valid = 1; long_rd = 0; long_data = 32'h55; tick();
    drv_idle(); tick();

    // Reset in the middle of outstanding work
    issue(1, 0, 0, 8); tick();
    issue(1, 0, 0, 9); tick();
    drv_idle(); long_valid = 1; long_rd = 8; reset = 1; tick(); tick();
    reset = 0; drv_idle(); tick();
    chk("post_reset_pending", 32'(pending), 32'd0);
    chk("post_reset_write", 32'(write), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 59) == 0);
      alu_valid  = ($urandom_range(0, 2) == 0);
      alu_rd     = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      long_valid = ($urandom_range(0, 1) == 0);
      start      = $urandom_range(0, 7);
      lrd        = 5'(start);
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (m_busy[(start + k) % 8]) begin
            lrd = 5'((start + k) % 8);
            break;
          end
        end
      end
      long_rd    = lrd;
      long_data  = $urandom;
      iss_valid  = ($urandom_range(0, 1) == 0);
      iss_long   = ($urandom_range(0, 1) == 0);
      iss_rs1    = 5'($urandom_range(0, 7));
      iss_rs2    = 5'($urandom_range(0, 7));
      iss_rd     = 5'($urandom_range(0, 7));
      tick();
    end

    reset = 0;
    drv_idle();
    repeat (3) tick();
    chk("queue_empty", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 SHALL have parameter MAX_PEND, default 4, max outstanding long-latency ops (1..7).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, consecutive blocked long-result cycles before ALU is held.
REQ-003 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- alu_valid  in  1  single-cycle ALU result present.
- alu_rd  in  5  ALU destination.
- alu_data  in  32  ALU result.
- alu_hold  out  1  upstream must freeze and re-present the ALU result.
- long_valid  in  1  load/mul/div result present.
- long_ready  out  1  long result accepted this cycle.
- long_rd  in  5  long destination.
- long_data  in  32  long result.
- iss_valid  in  1  decode presenting an instruction.
- iss_long  in  1  instruction is long-latency.
- iss_rs1  in  5  source 1.
- iss_rs2  in  5  source 2.
- iss_rd  in  5  destination.
- iss_stall  out  1  decode must hold the instruction.
- write  out  1  register-file write enable.
- wrAddr  out  5  register-file write address.
- wrData  out  32  register-file write data.
- pending  out  3  outstanding long-op count.

Function
REQ-004 SHALL register write/wrAddr/wrData; a result accepted in cycle N appears on them in cycle N+1 for exactly one cycle.
REQ-005 SHALL select ALU when alu_valid && !alu_hold; otherwise SHALL accept the long result when long_valid.
REQ-006 SHALL drive long_ready = !reset && !(alu_valid && !alu_hold), independent of long_valid.
REQ-007 SHALL force write=0 when the selected rd is 0; a long handshake to rd 0 still completes and decrements pending.
REQ-008 SHALL keep a starve counter: +1 each cycle long_valid && !long_ready, cleared on long handshake or !long_valid, saturating at STARVE_LIMIT.
REQ-009 SHALL assert alu_hold combinationally while starve counter == STARVE_LIMIT, so the long result is accepted in the next cycle.
REQ-010 SHALL keep a 32-bit busy vector; busy[0] is constant 0.
REQ-011 SHALL treat issue as accepted when iss_valid && !iss_stall; accepted with iss_long and iss_rd!=0 sets busy[iss_rd].
REQ-012 SHALL clear busy[long_rd] on the long handshake edge.
REQ-013 SHALL increment pending on accepted long issue, decrement on long handshake; both in one cycle leaves pending unchanged; decrement saturates at 0.
REQ-014 SHALL assert iss_stall when iss_valid and any of: busy[iss_rs1], busy[iss_rs2], busy[iss_rd], (write && wrAddr!=0 && wrAddr in {iss_rs1, iss_rs2}), (iss_long && pending==MAX_PEND).
REQ-015 SHALL evaluate iss_stall on pre-edge busy state; issue to a register being cleared in the same cycle stalls one cycle.
REQ-016 SHALL write a long result whose long_rd is not busy (protocol error) normally, leaving busy unchanged.
REQ-017 SHALL drive iss_stall=0 when iss_valid=0.

Reset
REQ-018 SHALL on reset clear busy, pending, starve counter, write, wrAddr, wrData to 0.
REQ-019 SHALL drive long_ready=0 and iss_stall=1 (when iss_valid) while reset is high.
REQ-020 SHALL drop any in-flight result on reset mid-operation; no write occurs in the cycle after reset.

Verification
REQ-021 Long issue rd=5 then iss rs1=5 -> iss_stall=1 until long handshake rd=5, data 0xDEADBEEF; next cycle write=1, wrAddr=5, wrData=0xDEADBEEF; stall drops the cycle after that.
REQ-022 alu_valid and long_valid held high 10 cycles -> long_ready=0 for 8 cycles, alu_hold=1 in cycle 9, long accepted cycle 9, starve counter 0 after.
REQ-023 Four long issues rd=1..4 then fifth iss_long -> pending=4, iss_stall=1; one long completion same cycle as fifth issue -> fifth accepted cycle after, pending stays 4.
REQ-024 ALU result rd=0, data 0x1234 -> write=0 next cycle; long result rd=0 -> long_ready=1, pending decremented, write=0.
REQ-025 Reset asserted with pending=2 and long_valid high -> long_ready=0 during reset; after release busy=0, pending=0, write=0.
